// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential signed divider.
package seq_divider_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] MOST_NEG = {1'b1, {(DIV_WIDTH - 1) {1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_sub_step.sv
// Combinational a - b as a + ~b + 1 over chained CLA cells; no_borrow is the final carry.
module div_sub_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             no_borrow_o
);
    localparam int unsigned Cells = WIDTH / 8;

    logic [Cells:0]   carry;
    logic [WIDTH-1:0] b_inv;

    assign b_inv    = ~b_i;
    assign carry[0] = 1'b1;

    for (genvar k = 0; k < Cells; k++) begin : g_cell
        seq_divider_cla8 u_cla (
            .a_i  (a_i[8*k +: 8]),
            .b_i  (b_inv[8*k +: 8]),
            .c_i  (carry[k]),
            .sum_o(diff_o[8*k +: 8]),
            .c_o  (carry[k+1])
        );
    end

    assign no_borrow_o = carry[Cells];

endmodule

// File: rtl/seq_divider_cla8.sv
// 8-bit carry-lookahead adder cell; each carry is expanded directly from g/p terms.
module seq_divider_cla8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       c_i,
    output logic [7:0] sum_o,
    output logic       c_o
);
    logic [7:0] gen;
    logic [7:0] prop;
    logic [8:0] carry;
    logic       acc;
    logic       run;

    always_comb begin
        gen   = a_i & b_i;
        prop  = a_i ^ b_i;
        carry = '0;
        acc   = 1'b0;
        run   = 1'b0;
        carry[0] = c_i;
        for (int i = 0; i < 8; i++) begin
            acc = gen[i];
            run = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (run & gen[j]);
                run = run & prop[j];
            end
            carry[i+1] = acc | (run & c_i);
        end
        sum_o = prop ^ carry[7:0];
        c_o   = carry[8];
    end

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed restoring divider: one quotient bit per cycle, start/ready handshake.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH - 1) {1'b0}}};
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic             negq_q, negq_d, negr_q, negr_d, exc_q, exc_d;
    logic [WIDTH-1:0] result_q, result_d, remainder_q, remainder_d;
    logic             exc_out_q, exc_out_d, rdy_q, rdy_d;

    logic [WIDTH-1:0] neg_a, neg_b, neg_quo, neg_rem;
    logic [WIDTH-1:0] abs_a, abs_b, shifted, trial;
    logic             no_borrow, b_zero, ovf;
    logic             unused_nb_a, unused_nb_b, unused_nb_q, unused_nb_r;

    // Negation is 0 - x through the same subtract step.
    div_sub_step #(.WIDTH(WIDTH)) u_neg_a (
        .a_i('0), .b_i(data_operandA), .diff_o(neg_a), .no_borrow_o(unused_nb_a)
    );
    div_sub_step #(.WIDTH(WIDTH)) u_neg_b (
        .a_i('0), .b_i(data_operandB), .diff_o(neg_b), .no_borrow_o(unused_nb_b)
    );
    div_sub_step #(.WIDTH(WIDTH)) u_neg_quo (
        .a_i('0), .b_i(quo_q), .diff_o(neg_quo), .no_borrow_o(unused_nb_q)
    );
    div_sub_step #(.WIDTH(WIDTH)) u_neg_rem (
        .a_i('0), .b_i(rem_q), .diff_o(neg_rem), .no_borrow_o(unused_nb_r)
    );
    div_sub_step #(.WIDTH(WIDTH)) u_step (
        .a_i(shifted), .b_i(dvs_q), .diff_o(trial), .no_borrow_o(no_borrow)
    );

    // quo_q starts as |A| and shifts dividend bits out of its MSB as quotient bits enter.
    assign shifted = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign abs_a   = data_operandA[WIDTH-1] ? neg_a : data_operandA;
    assign abs_b   = data_operandB[WIDTH-1] ? neg_b : data_operandB;
    assign b_zero  = (data_operandB == '0);
    assign ovf     = (data_operandA == MinNeg) && (data_operandB == '1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        exc_d       = exc_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        exc_out_d   = exc_out_q;
        rdy_d       = 1'b0;

        case (state_q)
            S_RUN: begin
                rem_d = no_borrow ? trial : shifted;
                quo_d = {quo_q[WIDTH-2:0], no_borrow};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) state_d = S_DONE;
            end
            S_DONE: begin
                result_d    = negq_q ? neg_quo : quo_q;
                remainder_d = negr_q ? neg_rem : rem_q;
                exc_out_d   = exc_q;
                rdy_d       = 1'b1;
                state_d     = S_IDLE;
            end
            default: ;
        endcase

        // A start in any state relatches; in DONE the finishing result still goes out.
        if (ctrl_div) begin
            quo_d   = b_zero ? '0 : abs_a;
            rem_d   = '0;
            dvs_d   = abs_b;
            negq_d  = ~b_zero & (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1]);
            negr_d  = ~b_zero & data_operandA[WIDTH-1];
            exc_d   = b_zero | ovf;
            cnt_d   = '0;
            state_d = b_zero ? S_DONE : S_RUN;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            exc_q       <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            exc_out_q   <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
            exc_q       <= exc_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            exc_out_q   <= exc_out_d;
            rdy_q       <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_exception = exc_out_q;
    assign data_resultRDY = rdy_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider; "cycle N" means the interval just after clock edge N.
module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         ctrl_div = 1'b0;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;
    logic [W-1:0] data_result, data_remainder;
    logic         data_exception, data_resultRDY, busy;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           rdy_cnt = 0;
    int           rdy_cyc = -1;
    logic [W-1:0] cap_res = '0;
    logic [W-1:0] cap_rem = '0;
    logic         cap_exc = 1'b0;

    always #5 clock = ~clock;

    seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ctrl_div      (ctrl_div),
        .data_operandA (opa),
        .data_operandB (opb),
        .data_result   (data_result),
        .data_remainder(data_remainder),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (data_resultRDY === 1'b1) begin
            rdy_cnt++;
            rdy_cyc = cyc;
            cap_res = data_result;
            cap_rem = data_remainder;
            cap_exc = data_exception;
        end
    endtask

    task automatic start(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clock);
        opa      = av;
        opb      = bv;
        ctrl_div = 1'b1;
        tick();
        ctrl_div = 1'b0;
    endtask

    task automatic clear_watch();
        cyc     = 0;
        rdy_cnt = 0;
        rdy_cyc = -1;
    endtask

    task automatic check_result(input string tag, input int exp_cyc, input logic [W-1:0] exp_q,
                                input logic [W-1:0] exp_r, input logic exp_e);
        chk({tag, ".rdy_count"}, W'(rdy_cnt), 1);
        chk({tag, ".rdy_cycle"}, W'(rdy_cyc), W'(exp_cyc));
        chk({tag, ".result"}, cap_res, exp_q);
        chk({tag, ".remainder"}, cap_rem, exp_r);
        chk({tag, ".exception"}, W'(cap_exc), W'(exp_e));
    endtask

    task automatic run_div(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                           input logic exp_e, input int exp_cyc);
        start(av, bv);
        clear_watch();
        chk({tag, ".busy_start"}, W'(busy), 1);
        repeat (40) tick();
        check_result(tag, exp_cyc, exp_q, exp_r, exp_e);
        chk({tag, ".busy_end"}, W'(busy), 0);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        @(posedge clock);
        #1;
        chk("reset.result", data_result, 0);
        chk("reset.remainder", data_remainder, 0);
        chk("reset.exception", W'(data_exception), 0);
        chk("reset.rdy", W'(data_resultRDY), 0);
        chk("reset.busy", W'(busy), 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        run_div("basic", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 33);
        run_div("neg_a", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
        run_div("neg_b", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
        run_div("neg_ab", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 33);
        run_div("div_zero", 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 1);
        run_div("ovf", MOST_NEG, 32'hFFFF_FFFF, MOST_NEG, 32'd0, 1'b1, 33);
        run_div("minneg_by_1", MOST_NEG, 32'd1, MOST_NEG, 32'd0, 1'b0, 33);
        run_div("m1_by_minneg", 32'hFFFF_FFFF, MOST_NEG, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);

        // Abort: second start lands on edge 10, only its result is strobed.
        start(32'd100, 32'd7);
        clear_watch();
        repeat (9) tick();
        start(32'd9, 32'd3);
        repeat (40) tick();
        check_result("abort", 43, 32'd3, 32'd0, 1'b0);

        // Start sampled on the DONE edge: old result strobes, new op runs straight through.
        start(32'd100, 32'd7);
        clear_watch();
        repeat (32) tick();
        start(32'd9, 32'd3);
        check_result("done_start_old", 33, 32'd14, 32'd2, 1'b0);
        rdy_cnt = 0;
        repeat (40) tick();
        check_result("done_start_new", 66, 32'd3, 32'd0, 1'b0);

        // Reset mid-operation, asserted between edges.
        start(32'd100, 32'd7);
        clear_watch();
        repeat (15) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("midreset.result", data_result, 0);
        chk("midreset.remainder", data_remainder, 0);
        chk("midreset.exception", W'(data_exception), 0);
        chk("midreset.rdy", W'(data_resultRDY), 0);
        chk("midreset.busy", W'(busy), 0);
        repeat (3) tick();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (40) tick();
        chk("midreset.no_strobe", W'(rdy_cnt), 0);
        run_div("after_reset", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multicycle signed integer divider for the processor's multdiv path.
- Performs truncating two's-complement division, one quotient bit per cycle, as restoring shift-and-subtract.
- The per-step subtract is built from the team's carry-lookahead adder cells; it is the inverse operation of the existing CLA add path.
- Results go back to the pipeline through a start/ready handshake.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 8 (CLA cell width).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ctrl_div  input  1  start pulse; operands are sampled on the edge where it is 1.
- data_operandA  input  WIDTH  dividend (signed).
- data_operandB  input  WIDTH  divisor (signed).
- data_result  output  WIDTH  quotient (signed, truncated toward zero).
- data_remainder  output  WIDTH  remainder; its sign follows the dividend.
- data_exception  output  1  divide-by-zero or overflow; valid only while data_resultRDY=1.
- data_resultRDY  output  1  single-cycle result-valid strobe.
- busy  output  1  high while in RUN or DONE.

Behaviour:
- Reset (reset_n=0, async assert, sync deassert to clock edge):
  - state=IDLE, counter=0.
  - All outputs 0: data_result, data_remainder, data_exception, data_resultRDY, busy.
- States: IDLE, RUN, DONE. Encoding is 2-bit binary, registered.
- IDLE:
  - ctrl_div=1 with B!=0: latch |A|, |B|, neg_q = A[MSB]^B[MSB], neg_r = A[MSB]. Clear partial remainder, counter=0. Go to RUN.
  - ctrl_div=1 with B==0: set exc_pending=1 and go directly to DONE (zero-divide fast path).
- RUN, each cycle:
  - trial = {rem[WIDTH-2:0], quo[MSB]} - |B|, computed as the sum with ~|B| and carry-in 1.
  - If carry-out is 1 (no borrow): rem=trial, shift quotient left inserting 1.
  - Otherwise: rem=shifted value, insert 0.
  - counter++.
  - When counter==WIDTH-1 at the edge, go to DONE.
- DONE, one cycle:
  - Registered outputs update: data_result = neg_q ? -quo : quo; data_remainder = neg_r ? -rem : rem.
  - data_resultRDY=1 for exactly that one cycle, then return to IDLE.
  - Outputs hold their values until the next DONE.
  - data_resultRDY returns to 0 in IDLE.
- Latency:
  - Normal case: data_resultRDY is high in the cycle after edge WIDTH+1, counting the start edge as edge 0. That is 33 cycles for WIDTH=32.
  - Zero divide: data_resultRDY is high after edge 1.
- Divide by zero: data_exception=1, data_result=0, data_remainder=0.
- Overflow (A = most negative value, B = -1):
  - Unsigned magnitude quotient 2^(WIDTH-1) wraps back to the most negative value.
  - data_result=0x80000000, data_remainder=0, data_exception=1.
  - Detected at start; the computation runs the full latency.
- Magnitude of the most negative value: |x| is taken as an unsigned WIDTH-bit value. -(0x80000000) = 0x80000000 unsigned is correct.
- ctrl_div=1 while busy: abort the current operation, relatch the new operands, and restart at RUN (or DONE for B==0). No data_resultRDY is issued for the aborted operation.
- ctrl_div=1 in the DONE cycle: the current result is still presented (data_resultRDY=1), and the new operation starts. The next state is RUN, not IDLE.
- reset_n low mid-operation: immediate return to the reset state; no strobe.

Decomposition:
- Shared include holds: state encodings (S_IDLE=0, S_RUN=1, S_DONE=2), the WIDTH default, and the most-negative constant.
- One sub-module, div_sub_step. It is combinational: inputs are shifted remainder and divisor, outputs are difference and no_borrow. It is built from WIDTH/8 chained 8-bit CLA cells, with carry-in 1 on ~divisor.
- Two's-complement negation reuses the same CLA cells (add of ~x with carry-in 1).

Test Plan:
- Basic: A=7, B=2, ctrl_div pulse -> at cycle 33, data_resultRDY=1, result=3, remainder=1, exception=0; RDY=0 in cycles 32 and 34.
- Signs: A=-7, B=2 -> result=-3, remainder=-1. A=7, B=-2 -> result=-3, remainder=1. A=-7, B=-2 -> result=3, remainder=-1.
- Zero divide: A=5, B=0 -> at cycle 1, RDY=1, exception=1, result=0, remainder=0.
- Overflow/extreme:
  - A=0x80000000, B=-1 -> cycle 33, result=0x80000000, exception=1.
  - A=0x80000000, B=1 -> result=0x80000000, exception=0.
  - A=0xFFFFFFFF(-1), B=0x80000000 -> result=0, remainder=-1.
- Abort: start 100/7, then at cycle 10 start 9/3 -> exactly one RDY, at cycle 43, with result=3 and remainder=0.
- Reset mid-op: start 100/7, pull reset_n low at cycle 15 (between edges) -> all outputs 0 immediately, no RDY. Then after release, 100/7 completes with result=14, remainder=2.
